// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states,
// queue entry layout and the halt opcode.
package fetch_pkg;

  localparam logic [7:0] HALT_OPCODE = 8'hF4;
  localparam int         ENTRY_W     = 75;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [39:0] instr;
    logic [2:0]  len;
  } fetch_entry_t;

  function automatic logic is_halt_op(input logic [7:0] opcode);
    return (opcode == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode; power-of-two depth,
// flush clears occupancy and pointers but leaves storage untouched.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  fetch_entry_t              push_entry,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count,
  output fetch_entry_t              head
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(QDEPTH);

  fetch_entry_t  mem_r [QDEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  // Qualify requests so the queue can never over- or under-run.
  always_comb begin
    push_s = push & ~flush & (count_r != CNT_MAX);
    pop_s  = pop & ~flush & (count_r != {(PW + 1){1'b0}});
  end

  // Entry storage, cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Status flags and head view straight from the registered state.
  always_comb begin
    full  = (count_r == CNT_MAX);
    empty = (count_r == {(PW + 1){1'b0}});
    count = count_r;
    head  = mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the INIT/RUN/HALT FSM and feeds
// fetched instructions to decode through fetch_queue.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] f_pc,
  output logic        f_pc_we,
  input  logic [39:0] f_instr,
  input  logic [31:0] f_next_pc,
  input  logic [2:0]  f_instr_length,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [39:0] d_instr,
  output logic [2:0]  d_length,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_r;
  fetch_state_t  state_next_s;
  logic [31:0]   pc_r;
  logic [31:0]   pc_next_s;
  logic          push_s;
  logic          pop_s;
  logic          q_full_s;
  logic          q_empty_s;
  logic [CW-1:0] q_count_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  // Push never looks at d_ready, keeping d_ready off the f_pc_we path.
  always_comb begin
    push_s             = (state_r == RUN) & ~q_full_s & ~redirect_valid;
    pop_s              = d_ready & ~q_empty_s;
    push_entry_s.pc    = pc_r;
    push_entry_s.instr = f_instr;
    push_entry_s.len   = f_instr_length;
  end

  // Next state and next PC; redirect overrides everything.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    if (redirect_valid) begin
      state_next_s = RUN;
      pc_next_s    = redirect_pc;
    end else begin
      case (state_r)
        INIT:    state_next_s = RUN;
        RUN:     state_next_s = (push_s && is_halt_op(f_instr[7:0])) ? HALT : RUN;
        HALT:    state_next_s = HALT;
        default: state_next_s = INIT;
      endcase
      if (push_s) begin
        pc_next_s = f_next_pc;
      end else begin
        pc_next_s = pc_r;
      end
    end
  end

  // FSM state and architectural PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .push_entry (push_entry_s),
    .full       (q_full_s),
    .empty      (q_empty_s),
    .count      (q_count_s),
    .head       (head_s)
  );

  // Port views of the PC, handshake and queue head.
  always_comb begin
    f_pc     = pc_r;
    f_pc_we  = push_s;
    d_valid  = (q_count_s != {CW{1'b0}});
    d_pc     = head_s.pc;
    d_instr  = head_s.instr;
    d_length = head_s.len;
    halted   = (state_r == HALT);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          QD  = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pc_we;
  logic [39:0] f_instr;
  logic [31:0] f_next_pc;
  logic [2:0]  f_instr_length;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [39:0] d_instr;
  logic [2:0]  d_length;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  fetch_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_pc           (f_pc),
    .f_pc_we        (f_pc_we),
    .f_instr        (f_instr),
    .f_next_pc      (f_next_pc),
    .f_instr_length (f_instr_length),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_pc           (d_pc),
    .d_instr        (d_instr),
    .d_length       (d_length),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [39:0] instr;
    logic [2:0]  len;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic [31:0] fpc;
    logic        we;
    logic        valid;
    logic [31:0] dpc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model: PC, in-order queue, init/halt flags
  logic [31:0] m_pc;
  ent_t        mq[$];
  logic        m_init;
  logic        m_halt;
  logic        rand_mode;

  // values sampled in the most recent cycle
  logic [31:0] s_fpc;
  logic        s_we;
  logic        s_valid;
  logic [31:0] s_dpc;
  logic [2:0]  s_dlen;
  logic        s_halted;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    mq.delete();
    m_init = 1'b1;
    m_halt = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_f_pc", 64'(f_pc), 64'(RPC));
    chk("rst_f_pc_we", 64'(f_pc_we), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_pc", 64'(d_pc), 64'd0);
    chk("rst_d_instr", 64'(d_instr), 64'd0);
    chk("rst_d_length", 64'(d_length), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
  endtask

  // fetch-stage stand-in: produces bytes for whatever PC the DUT presents
  task automatic drive_fetch();
    logic [31:0] p;
    logic [31:0] hi;
    logic [7:0]  op;
    p = f_pc;
    if (rand_mode) begin
      op = ($urandom_range(0, 5) == 0) ? 8'hF4 : 8'($urandom_range(0, 255));
      hi = $urandom();
      f_instr        = {hi, op};
      f_instr_length = 3'($urandom_range(1, 5));
      f_next_pc      = p + 32'(f_instr_length);
    end else if (p == 32'h0000_0200) begin
      f_instr        = {32'h0000_0010, 8'hE9};
      f_instr_length = 3'd5;
      f_next_pc      = p + 32'd5 + 32'h10;
    end else if (p == 32'h0000_0300) begin
      f_instr        = {32'h0000_0000, 8'hF4};
      f_instr_length = 3'd1;
      f_next_pc      = p + 32'd1;
    end else begin
      f_instr        = {p, 8'h90};
      f_instr_length = 3'd1;
      f_next_pc      = p + 32'd1;
    end
  endtask

  // one clock cycle: drive at negedge, compare against model, advance model
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic exp_we;
    logic exp_valid;
    ent_t e;
    d_ready        = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    drive_fetch();
    #1;
    exp_we    = !m_init && !m_halt && (mq.size() < QD) && !rv;
    exp_valid = (mq.size() != 0);
    s_fpc = f_pc; s_we = f_pc_we; s_valid = d_valid;
    s_dpc = d_pc; s_dlen = d_length; s_halted = halted;
    chk("f_pc", 64'(f_pc), 64'(m_pc));
    chk("f_pc_we", 64'(f_pc_we), 64'(exp_we));
    chk("d_valid", 64'(d_valid), 64'(exp_valid));
    chk("halted", 64'(halted), 64'(m_halt));
    if (exp_valid) begin
      chk("d_pc", 64'(d_pc), 64'(mq[0].pc));
      chk("d_instr", 64'(d_instr), 64'(mq[0].instr));
      chk("d_length", 64'(d_length), 64'(mq[0].len));
    end
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
      m_init = 1'b0;
    end else begin
      if (exp_valid && rdy) void'(mq.pop_front());
      if (exp_we) begin
        e.pc = m_pc; e.instr = f_instr; e.len = f_instr_length;
        mq.push_back(e);
        m_pc = f_next_pc;
        if (f_instr[7:0] == 8'hF4) m_halt = 1'b1;
      end
      m_init = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h000};
    tbl[1] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h000};
    tbl[2] = '{1'b1, 32'h101, 1'b1, 1'b1, 32'h100};
    tbl[3] = '{1'b0, 32'h102, 1'b1, 1'b1, 32'h101};
    tbl[4] = '{1'b0, 32'h103, 1'b0, 1'b1, 32'h101};
    tbl[5] = '{1'b0, 32'h103, 1'b0, 1'b1, 32'h101};
    tbl[6] = '{1'b1, 32'h103, 1'b0, 1'b1, 32'h101};
    tbl[7] = '{1'b1, 32'h103, 1'b1, 1'b1, 32'h102};
    tbl[8] = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h103};

    rst_n = 1'b0; d_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    f_instr = 40'h0; f_next_pc = 32'h0; f_instr_length = 3'd1; rand_mode = 1'b0;
    @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // reset release and back-pressure
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].rdy, 1'b0, 32'h0);
      chk("tbl_f_pc", 64'(s_fpc), 64'(tbl[i].fpc));
      chk("tbl_f_pc_we", 64'(s_we), 64'(tbl[i].we));
      chk("tbl_d_valid", 64'(s_valid), 64'(tbl[i].valid));
      if (tbl[i].valid) chk("tbl_d_pc", 64'(s_dpc), 64'(tbl[i].dpc));
    end

    // jump instruction
    cyc(1'b1, 1'b1, 32'h200);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("jmp_len", 64'(s_dlen), 64'd5);
    chk("jmp_d_pc", 64'(s_dpc), 64'h200);
    cyc(1'b1, 1'b0, 32'h0);
    chk("jmp_target", 64'(s_dpc), 64'h215);

    // halt, then drain
    cyc(1'b1, 1'b1, 32'h300);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("halt_flag", 64'(s_halted), 64'd1);
    chk("halt_f_pc", 64'(s_fpc), 64'h301);
    chk("halt_entry", 64'(s_dpc), 64'h300);
    repeat (4) cyc(1'b1, 1'b0, 32'h0);
    chk("halt_drained", 64'(s_valid), 64'd0);
    chk("halt_pc_hold", 64'(s_fpc), 64'h301);

    // full queue in HALT, then redirect
    cyc(1'b0, 1'b1, 32'h2FF);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("halt_full", 64'(s_halted), 64'd1);
    cyc(1'b0, 1'b1, 32'h400);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rdh_valid", 64'(s_valid), 64'd0);
    chk("rdh_f_pc", 64'(s_fpc), 64'h400);
    chk("rdh_halted", 64'(s_halted), 64'd0);

    // full queue in RUN, then redirect
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h400);
    cyc(1'b0, 1'b1, 32'h500);
    chk("rdr_valid", 64'(s_valid), 64'd0);
    chk("rdr_f_pc", 64'(s_fpc), 64'h400);
    chk("rdr_no_push", 64'(s_we), 64'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rdr_new_pc", 64'(s_fpc), 64'h500);

    // async reset between edges with a populated queue
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h0);
    chk("rst_init_f_pc", 64'(s_fpc), 64'(RPC));
    chk("rst_init_we", 64'(s_we), 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rst_first_push", 64'(s_we), 64'd1);

    // randomized traffic against the model
    rand_mode = 1'b1;
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the fetch stage: owns the architectural PC register, drives the fetch stage's `pc`/`pc_we` inputs, and captures each fetched instruction into a small in-order queue presented to decode over a valid/ready handshake. It also handles halt detection (opcode `F4`) and redirects from execute, which flush the queue and reload the PC. It sits between the fetch stage and decode.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `QDEPTH`, default 2: queue entries; a power of two, minimum 2.
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): reset, asynchronous and active-low.
- `f_pc` (out, 32): PC presented to the fetch stage; equals the PC register.
- `f_pc_we` (out, 1): high in a cycle where the current instruction is accepted (push).
- `f_instr` (in, 40): fetched bytes; the opcode is `f_instr[7:0]`.
- `f_next_pc` (in, 32): fetch-stage next PC, valid when `f_pc_we=1`.
- `f_instr_length` (in, 3): fetch-stage length, 1 to 5.
- `d_valid` (out, 1): queue head valid.
- `d_ready` (in, 1): decode accepts the head.
- `d_pc` (out, 32), `d_instr` (out, 40), `d_length` (out, 3): queue head fields.
- `redirect_valid` (in, 1), `redirect_pc` (in, 32): execute-stage redirect.
- `halted` (out, 1): the controller is in HALT.

## Operation
- **States:**
  - INIT: first cycle after reset; no push.
  - RUN: fetching.
  - HALT: no fetching, queue drains.
- **Transitions:**
  - INIT→RUN unconditionally.
  - RUN→HALT on a push whose opcode is `F4`; the halt entry itself is enqueued.
  - Any state→RUN on `redirect_valid`.
- **Push:** `push = (state==RUN) & (count<QDEPTH) & ~redirect_valid`.
  - On push: enqueue {`f_pc`, `f_instr`, `f_instr_length`} and set PC to `f_next_pc`.
  - `f_pc_we = push`.
  - Push does not depend on `d_ready`, so there is no combinational path from `d_ready` to `f_pc_we`. A full queue does not push even if it pops in the same cycle.
- **Pop:** `pop = d_valid & d_ready`, with `d_valid = (count!=0)`. Head fields come from the read pointer; when empty they show the stale entry.
- **Redirect:** has priority over everything.
  - PC is set to `redirect_pc`, count and pointers clear, state goes to RUN.
  - A pop in the same cycle is still a completed handshake from decode's view.
  - A redirect arriving in HALT resumes fetching.
- **Widths:** PC arithmetic is done by the fetch stage; wrap at 2^32 is accepted unchanged. `count` is $clog2(QDEPTH)+1 bits. Pointers wrap modulo QDEPTH.
- **In HALT:** the PC holds, pops continue until empty, and `halted` stays 1 until a redirect or reset.

## Timing
- **Reset values:** PC = `RESET_PC`, state = INIT, count = 0, pointers = 0, all queue storage = 0.
- **Outputs while in reset:** `f_pc=RESET_PC`, `f_pc_we=0`, `d_valid=0`, `d_pc=0`, `d_instr=0`, `d_length=0`, `halted=0`.
- **Push latency:** a push at edge N gives `d_valid=1` with that entry from cycle N+1. The new `f_pc` is also visible from N+1.
- **Throughput:** one instruction per cycle with `d_ready` held high.
- **Redirect:** asserted in cycle N gives `f_pc=redirect_pc` and `d_valid=0` in N+1. The first push from the new PC is at the end of N+1.
- **Halt:** a push of `F4` at edge N gives `halted=1` from N+1. `f_pc` holds `halt_pc+1` from then on.
- **Reset mid-operation:** `rst_n` low immediately forces all reset values, including mid-queue and mid-halt.

## Structure
- **Package `fetch_pkg`:** the `HALT_OPCODE` (`8'hF4`) constant, the `fetch_state_t` enum (INIT/RUN/HALT), the `fetch_entry_t` struct {pc[31:0], instr[39:0], len[2:0]}, and the entry width constant (75).
- **Sub-module `fetch_queue`:** parameterised on QDEPTH, with push/pop/flush inputs, full/empty/count outputs, and the head entry.
- **`fetch_ctrl` proper:** holds the PC register, the FSM and the push/redirect priority logic.

## Test plan
- **Reset release:** `RESET_PC=0x100`, `d_ready=1`, stream of NOPs (`90`).
  - `f_pc_we=0` in the INIT cycle.
  - Pushes of 0x100, 0x101 and 0x102 follow on consecutive cycles.
  - `d_pc` follows one cycle later.
- **Back-pressure:** `d_ready=0` with QDEPTH=2.
  - Exactly two pushes occur, then `f_pc_we=0` and `f_pc` holds.
  - Raising `d_ready` gives one pop per cycle and resumes pushing; no entry is lost or duplicated.
- **Jump:** `E9` at 0x200 with offset 0x10.
  - The pushed entry has `d_length=5`.
  - The next push has `d_pc=0x215`.
- **Halt:** `F4` at 0x300.
  - The entry is enqueued and `halted=1` on the next cycle.
  - `f_pc` stays at 0x301.
  - The queue drains, then `d_valid=0` stays low.
- **Redirect:** queue full, then `redirect_valid` with `redirect_pc=0x400`, both during RUN and during HALT.
  - Next cycle `d_valid=0`, `f_pc=0x400`, `halted=0`.
  - Redirect in the same cycle as a would-be push gives no push.
- **Async reset mid-stream:** assert `rst_n` low between clock edges.
  - All outputs take their reset values immediately.
  - Restart begins from `RESET_PC`.
